// File: rtl/cb_reg_bus_master.sv
// cb_reg_bus_master: single-command initiator for the CB switch register bus.
// Accepts one read/write command, issues one bus transaction and returns one
// response. Read waits are bounded by RD_TIMEOUT cycles.
// Optional: define CB_REG_MASTER_WR_VERIFY_EN to read back every write and flag
// a mismatch in the response.
module cb_reg_bus_master #(
    parameter int REG_ADDR_BUS_WIDTH = 8,
    parameter int REG_DATA_BUS_WIDTH = 16,
    parameter int RD_TIMEOUT         = 16
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_cmd_valid,
    output logic                          o_cmd_ready,
    input  logic                          i_cmd_wr,
    input  logic [REG_ADDR_BUS_WIDTH-1:0] i_cmd_addr,
    input  logic [REG_DATA_BUS_WIDTH-1:0] i_cmd_wdata,
    output logic                          o_switch_reg_bus_we,
    output logic [REG_ADDR_BUS_WIDTH-1:0] o_switch_reg_bus_we_addr,
    output logic [REG_DATA_BUS_WIDTH-1:0] o_switch_reg_bus_we_din,
    output logic                          o_switch_reg_bus_we_din_v,
    output logic                          o_switch_reg_bus_rd,
    output logic [REG_ADDR_BUS_WIDTH-1:0] o_switch_reg_bus_rd_addr,
    input  logic [REG_DATA_BUS_WIDTH-1:0] i_switch_reg_bus_rd_dout,
    input  logic                          i_switch_reg_bus_rd_dout_v,
    output logic                          o_rsp_valid,
    input  logic                          i_rsp_ready,
    output logic                          o_rsp_wr,
    output logic [REG_DATA_BUS_WIDTH-1:0] o_rsp_rdata,
    output logic                          o_rsp_err,
    output logic                          o_busy,
    output logic [7:0]                    o_timeout_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ_REQ,
        READ_WAIT,
        RESP
    } state_t;

    // Wait-counter value of the last READ_WAIT cycle before giving up.
    localparam logic [7:0] WAIT_LAST = 8'(RD_TIMEOUT - 1);

    state_t                        state_q, state_d;
    logic                          wr_q, wr_d;
    logic [REG_ADDR_BUS_WIDTH-1:0] addr_q, addr_d;
    logic [REG_DATA_BUS_WIDTH-1:0] wdata_q, wdata_d;
    logic [7:0]                    waitCnt_q, waitCnt_d;
    logic [REG_DATA_BUS_WIDTH-1:0] rdata_q, rdata_d;
    logic                          err_q, err_d;
    logic [7:0]                    timeoutCnt_q, timeoutCnt_d;

    logic                          cmdReady_q, cmdReady_d;
    logic                          we_q, we_d;
    logic [REG_ADDR_BUS_WIDTH-1:0] weAddr_q, weAddr_d;
    logic [REG_DATA_BUS_WIDTH-1:0] weDin_q, weDin_d;
    logic                          rd_q, rd_d;
    logic [REG_ADDR_BUS_WIDTH-1:0] rdAddr_q, rdAddr_d;
    logic                          rspValid_q, rspValid_d;
    logic                          rspWr_q, rspWr_d;
    logic [REG_DATA_BUS_WIDTH-1:0] rspRdata_q, rspRdata_d;
    logic                          rspErr_q, rspErr_d;
    logic                          busy_q, busy_d;

    // Next-state logic, then registered outputs decoded from the state being entered.
    always_comb begin
        state_d      = state_q;
        wr_d         = wr_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        waitCnt_d    = waitCnt_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        timeoutCnt_d = timeoutCnt_q;

        cmdReady_d   = 1'b0;
        we_d         = 1'b0;
        weAddr_d     = '0;
        weDin_d      = '0;
        rd_d         = 1'b0;
        rdAddr_d     = '0;
        rspValid_d   = 1'b0;
        rspWr_d      = 1'b0;
        rspRdata_d   = '0;
        rspErr_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_cmd_valid && cmdReady_q) begin
                    wr_d    = i_cmd_wr;
                    addr_d  = i_cmd_addr;
                    wdata_d = i_cmd_wdata;
                    state_d = i_cmd_wr ? WRITE : READ_REQ;
                end
            end
            WRITE: begin
                rdata_d = '0;
                err_d   = 1'b0;
`ifdef CB_REG_MASTER_WR_VERIFY_EN
                state_d = READ_REQ;
`else
                state_d = RESP;
`endif
            end
            READ_REQ: begin
                waitCnt_d = '0;
                state_d   = READ_WAIT;
            end
            READ_WAIT: begin
                waitCnt_d = waitCnt_q + 8'd1;
                if (i_switch_reg_bus_rd_dout_v) begin
                    rdata_d = i_switch_reg_bus_rd_dout;
`ifdef CB_REG_MASTER_WR_VERIFY_EN
                    err_d   = wr_q && (i_switch_reg_bus_rd_dout != wdata_q);
`else
                    err_d   = 1'b0;
`endif
                    state_d = RESP;
                end else if (waitCnt_q == WAIT_LAST) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    if (timeoutCnt_q != 8'hFF) begin
                        timeoutCnt_d = timeoutCnt_q + 8'd1;
                    end
                    state_d = RESP;
                end
            end
            RESP: begin
                if (i_rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        case (state_d)
            IDLE:     cmdReady_d = 1'b1;
            WRITE: begin
                we_d     = 1'b1;
                weAddr_d = addr_d;
                weDin_d  = wdata_d;
            end
            READ_REQ: begin
                rd_d     = 1'b1;
                rdAddr_d = addr_d;
            end
            RESP: begin
                rspValid_d = 1'b1;
                rspWr_d    = wr_d;
                rspRdata_d = rdata_d;
                rspErr_d   = err_d;
            end
            default: ;
        endcase

        busy_d = (state_d != IDLE);
    end

    // State, captured command and output registers; reset returns everything to idle zeros.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= IDLE;
            wr_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            waitCnt_q    <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            timeoutCnt_q <= '0;
            cmdReady_q   <= 1'b0;
            we_q         <= 1'b0;
            weAddr_q     <= '0;
            weDin_q      <= '0;
            rd_q         <= 1'b0;
            rdAddr_q     <= '0;
            rspValid_q   <= 1'b0;
            rspWr_q      <= 1'b0;
            rspRdata_q   <= '0;
            rspErr_q     <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_q         <= wr_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            waitCnt_q    <= waitCnt_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            timeoutCnt_q <= timeoutCnt_d;
            cmdReady_q   <= cmdReady_d;
            we_q         <= we_d;
            weAddr_q     <= weAddr_d;
            weDin_q      <= weDin_d;
            rd_q         <= rd_d;
            rdAddr_q     <= rdAddr_d;
            rspValid_q   <= rspValid_d;
            rspWr_q      <= rspWr_d;
            rspRdata_q   <= rspRdata_d;
            rspErr_q     <= rspErr_d;
            busy_q       <= busy_d;
        end
    end

    assign o_cmd_ready               = cmdReady_q;
    assign o_switch_reg_bus_we       = we_q;
    assign o_switch_reg_bus_we_addr  = weAddr_q;
    assign o_switch_reg_bus_we_din   = weDin_q;
    assign o_switch_reg_bus_we_din_v = we_q;
    assign o_switch_reg_bus_rd       = rd_q;
    assign o_switch_reg_bus_rd_addr  = rdAddr_q;
    assign o_rsp_valid               = rspValid_q;
    assign o_rsp_wr                  = rspWr_q;
    assign o_rsp_rdata               = rspRdata_q;
    assign o_rsp_err                 = rspErr_q;
    assign o_busy                    = busy_q;
    assign o_timeout_cnt             = timeoutCnt_q;

endmodule

// File: tb/tb_cb_reg_bus_master.sv
// Directed testbench for cb_reg_bus_master with a 2-cycle CB register slave model.
// Handles both builds (CB_REG_MASTER_WR_VERIFY_EN defined or not).
module tb_cb_reg_bus_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmdValid;
    logic        cmdReady;
    logic        cmdWr;
    logic [7:0]  cmdAddr;
    logic [15:0] cmdWdata;
    logic        we;
    logic [7:0]  weAddr;
    logic [15:0] weDin;
    logic        weDinV;
    logic        rd;
    logic [7:0]  rdAddr;
    logic [15:0] rdDout;
    logic        rdDoutV;
    logic        rspValid;
    logic        rspReady;
    logic        rspWr;
    logic [15:0] rspRdata;
    logic        rspErr;
    logic        busy;
    logic [7:0]  timeoutCnt;

    int checks   = 0;
    int failures = 0;

    // Slave model controls
    logic        slaveEnable;
    logic        forceEn;
    logic [15:0] forceVal;
    logic        injectV;
    logic [15:0] injectD;
    logic        pipeV1, pipeV2;
    logic [15:0] pipeD1, pipeD2;
    logic [15:0] slaveMem [0:255];

`ifdef CB_REG_MASTER_WR_VERIFY_EN
    localparam int EXP_HANDSHAKES = 2;
`else
    localparam int EXP_HANDSHAKES = 3;
`endif

    // 250 MHz clock
    always #2 clk = ~clk;

    cb_reg_bus_master #(
        .REG_ADDR_BUS_WIDTH(8),
        .REG_DATA_BUS_WIDTH(16),
        .RD_TIMEOUT(16)
    ) dut (
        .i_clk                      (clk),
        .i_rst                      (rst),
        .i_cmd_valid                (cmdValid),
        .o_cmd_ready                (cmdReady),
        .i_cmd_wr                   (cmdWr),
        .i_cmd_addr                 (cmdAddr),
        .i_cmd_wdata                (cmdWdata),
        .o_switch_reg_bus_we        (we),
        .o_switch_reg_bus_we_addr   (weAddr),
        .o_switch_reg_bus_we_din    (weDin),
        .o_switch_reg_bus_we_din_v  (weDinV),
        .o_switch_reg_bus_rd        (rd),
        .o_switch_reg_bus_rd_addr   (rdAddr),
        .i_switch_reg_bus_rd_dout   (rdDout),
        .i_switch_reg_bus_rd_dout_v (rdDoutV),
        .o_rsp_valid                (rspValid),
        .i_rsp_ready                (rspReady),
        .o_rsp_wr                   (rspWr),
        .o_rsp_rdata                (rspRdata),
        .o_rsp_err                  (rspErr),
        .o_busy                     (busy),
        .o_timeout_cnt              (timeoutCnt)
    );

    // CB register slave: writes land immediately, reads return two cycles after rd
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) slaveMem[i] <= 16'h0000;
            slaveMem[1] <= 16'h0004;
            pipeV1 <= 1'b0;
            pipeV2 <= 1'b0;
            pipeD1 <= 16'h0000;
            pipeD2 <= 16'h0000;
        end else begin
            if (we) slaveMem[weAddr] <= weDin;
            pipeV1 <= rd & slaveEnable;
            pipeD1 <= forceEn ? forceVal : slaveMem[rdAddr];
            pipeV2 <= pipeV1;
            pipeD2 <= pipeD1;
        end
    end

    assign rdDoutV = pipeV2 | injectV;
    assign rdDout  = injectV ? injectD : (pipeV2 ? pipeD2 : 16'h0000);

    // Advance one cycle; inputs are driven and outputs sampled 1 ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Present one command and complete its handshake; returns in cycle T+1
    task automatic applyStimulus(input logic wr, input logic [7:0] addr, input logic [15:0] wdata);
        int n = 0;
        while (!cmdReady && n < 64) begin
            tick();
            n++;
        end
        if (!cmdReady) checkOutput("cmdReadyWait", {31'd0, cmdReady}, 32'd1);
        cmdValid = 1'b1;
        cmdWr    = wr;
        cmdAddr  = addr;
        cmdWdata = wdata;
        tick();
        cmdValid = 1'b0;
        cmdWr    = 1'b0;
        cmdAddr  = 8'h00;
        cmdWdata = 16'h0000;
    endtask

    task automatic waitForResponse(input string tag);
        int n = 0;
        while (!rspValid && n < 64) begin
            tick();
            n++;
        end
        checkOutput(tag, {31'd0, rspValid}, 32'd1);
    endtask

    task automatic consumeResponse();
        rspReady = 1'b1;
        tick();
        rspReady = 1'b0;
    endtask

    initial begin
        int hs;
        rst         = 1'b1;
        cmdValid    = 1'b0;
        cmdWr       = 1'b0;
        cmdAddr     = 8'h00;
        cmdWdata    = 16'h0000;
        rspReady    = 1'b0;
        slaveEnable = 1'b1;
        forceEn     = 1'b0;
        forceVal    = 16'h0000;
        injectV     = 1'b0;
        injectD     = 16'h0000;

        // Reset held for three cycles
        repeat (3) tick();
        checkOutput("rstCmdReady", {31'd0, cmdReady}, 32'd0);
        checkOutput("rstWe", {31'd0, we}, 32'd0);
        checkOutput("rstRd", {31'd0, rd}, 32'd0);
        checkOutput("rstRspValid", {31'd0, rspValid}, 32'd0);
        checkOutput("rstBusy", {31'd0, busy}, 32'd0);
        checkOutput("rstTimeoutCnt", {24'd0, timeoutCnt}, 32'd0);
        rst = 1'b0;
        tick();
        checkOutput("postRstCmdReady", {31'd0, cmdReady}, 32'd1);
        checkOutput("postRstTimeoutCnt", {24'd0, timeoutCnt}, 32'd0);

        // Write 0x1234 to address 0x02
        applyStimulus(1'b1, 8'h02, 16'h1234);
        checkOutput("wrWe", {31'd0, we}, 32'd1);
        checkOutput("wrDinV", {31'd0, weDinV}, 32'd1);
        checkOutput("wrAddr", {24'd0, weAddr}, 32'h02);
        checkOutput("wrDin", {16'd0, weDin}, 32'h1234);
        checkOutput("wrNoRd", {31'd0, rd}, 32'd0);
        checkOutput("wrCmdReady", {31'd0, cmdReady}, 32'd0);
        checkOutput("wrBusy", {31'd0, busy}, 32'd1);
        tick();
        checkOutput("wrWeDrop", {31'd0, we}, 32'd0);
        checkOutput("wrAddrIdle", {24'd0, weAddr}, 32'd0);
        checkOutput("wrDinIdle", {16'd0, weDin}, 32'd0);
`ifdef CB_REG_MASTER_WR_VERIFY_EN
        checkOutput("wrVerifyRd", {31'd0, rd}, 32'd1);
        checkOutput("wrVerifyRdAddr", {24'd0, rdAddr}, 32'h02);
        waitForResponse("wrVerifyRspWait");
        checkOutput("wrVerifyRdata", {16'd0, rspRdata}, 32'h1234);
`else
        checkOutput("wrRspValid", {31'd0, rspValid}, 32'd1);
        checkOutput("wrNoRd2", {31'd0, rd}, 32'd0);
        checkOutput("wrRdata", {16'd0, rspRdata}, 32'd0);
`endif
        checkOutput("wrRspWr", {31'd0, rspWr}, 32'd1);
        checkOutput("wrRspErr", {31'd0, rspErr}, 32'd0);
        consumeResponse();
        checkOutput("wrDoneCmdReady", {31'd0, cmdReady}, 32'd1);
        checkOutput("wrDoneRspValid", {31'd0, rspValid}, 32'd0);

        // Back-to-back writes with the response side always ready
        hs = 0;
        cmdValid = 1'b1;
        cmdWr    = 1'b1;
        cmdAddr  = 8'h03;
        cmdWdata = 16'h0055;
        rspReady = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (cmdReady) hs++;
            tick();
        end
        cmdValid = 1'b0;
        cmdWr    = 1'b0;
        checkOutput("b2bHandshakes", hs, EXP_HANDSHAKES);
        repeat (8) tick();
        rspReady = 1'b0;
        checkOutput("b2bIdle", {31'd0, busy}, 32'd0);

        // Read address 0x01 from the slave, response held back for five cycles
        applyStimulus(1'b0, 8'h01, 16'h0000);
        checkOutput("rdStrobe", {31'd0, rd}, 32'd1);
        checkOutput("rdAddr", {24'd0, rdAddr}, 32'h01);
        checkOutput("rdNoWe", {31'd0, we}, 32'd0);
        tick();
        checkOutput("rdStrobeDrop", {31'd0, rd}, 32'd0);
        checkOutput("rdAddrIdle", {24'd0, rdAddr}, 32'd0);
        tick();
        checkOutput("rdNoEarlyRsp", {31'd0, rspValid}, 32'd0);
        tick();
        checkOutput("rdRspValid", {31'd0, rspValid}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("rdHoldValid", {31'd0, rspValid}, 32'd1);
            checkOutput("rdHoldData", {16'd0, rspRdata}, 32'h0004);
            checkOutput("rdHoldCmdReady", {31'd0, cmdReady}, 32'd0);
        end
        checkOutput("rdRspWr", {31'd0, rspWr}, 32'd0);
        checkOutput("rdRspErr", {31'd0, rspErr}, 32'd0);
        consumeResponse();
        checkOutput("rdDoneCmdReady", {31'd0, cmdReady}, 32'd1);

        // Silent slave: timeout 16 cycles after READ_WAIT entry
        slaveEnable = 1'b0;
        applyStimulus(1'b0, 8'h01, 16'h0000);
        repeat (16) tick();
        checkOutput("toNotYet", {31'd0, rspValid}, 32'd0);
        tick();
        checkOutput("toRspValid", {31'd0, rspValid}, 32'd1);
        checkOutput("toErr", {31'd0, rspErr}, 32'd1);
        checkOutput("toRdata", {16'd0, rspRdata}, 32'd0);
        checkOutput("toCnt1", {24'd0, timeoutCnt}, 32'd1);
        consumeResponse();

        // Data arriving on the final timeout cycle wins
        applyStimulus(1'b0, 8'h01, 16'h0000);
        repeat (16) tick();
        injectV = 1'b1;
        injectD = 16'hBEEF;
        tick();
        injectV = 1'b0;
        injectD = 16'h0000;
        checkOutput("edgeRspValid", {31'd0, rspValid}, 32'd1);
        checkOutput("edgeErr", {31'd0, rspErr}, 32'd0);
        checkOutput("edgeRdata", {16'd0, rspRdata}, 32'hBEEF);
        checkOutput("edgeCntSame", {24'd0, timeoutCnt}, 32'd1);
        consumeResponse();

        // Stray read-data valid while idle
        injectV = 1'b1;
        injectD = 16'h1111;
        tick();
        injectV = 1'b0;
        injectD = 16'h0000;
        repeat (2) tick();
        checkOutput("strayNoRsp", {31'd0, rspValid}, 32'd0);
        checkOutput("strayNotBusy", {31'd0, busy}, 32'd0);

        // 299 more timeouts: counter saturates at 255
        for (int i = 0; i < 299; i++) begin
            applyStimulus(1'b0, 8'h05, 16'h0000);
            waitForResponse("toLoopRsp");
            consumeResponse();
        end
        checkOutput("toCntSat", {24'd0, timeoutCnt}, 32'd255);

        // Reset in the middle of a read
        slaveEnable = 1'b1;
        applyStimulus(1'b0, 8'h01, 16'h0000);
        rst = 1'b1;
        tick();
        checkOutput("midRstRd", {31'd0, rd}, 32'd0);
        checkOutput("midRstBusy", {31'd0, busy}, 32'd0);
        checkOutput("midRstCnt", {24'd0, timeoutCnt}, 32'd0);
        checkOutput("midRstCmdReady", {31'd0, cmdReady}, 32'd0);
        rst = 1'b0;
        tick();
        checkOutput("midRstReady", {31'd0, cmdReady}, 32'd1);
        repeat (4) tick();
        checkOutput("midRstNoRsp", {31'd0, rspValid}, 32'd0);

`ifdef CB_REG_MASTER_WR_VERIFY_EN
        // Write-verify: matching readback
        applyStimulus(1'b1, 8'h00, 16'h000A);
        waitForResponse("vfyOkWait");
        checkOutput("vfyOkWr", {31'd0, rspWr}, 32'd1);
        checkOutput("vfyOkRdata", {16'd0, rspRdata}, 32'h000A);
        checkOutput("vfyOkErr", {31'd0, rspErr}, 32'd0);
        consumeResponse();

        // Write-verify: slave returns a different value
        forceEn  = 1'b1;
        forceVal = 16'h000B;
        applyStimulus(1'b1, 8'h00, 16'h000A);
        waitForResponse("vfyBadWait");
        checkOutput("vfyBadWr", {31'd0, rspWr}, 32'd1);
        checkOutput("vfyBadRdata", {16'd0, rspRdata}, 32'h000B);
        checkOutput("vfyBadErr", {31'd0, rspErr}, 32'd1);
        consumeResponse();
        forceEn = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
